fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the PC register and next-PC mux.
- Owns the fetch PC and issues one word request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents each fetched instruction with its PC and PC+4 to decode, and holds it while decode stalls.
- Applies branch/jump redirects from the ALU, and discards stale in-flight responses after a redirect.

---
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one imem request at a time and
// holds each fetched word for decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        br_sel_i,
  input  logic [31:0] alu_data_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        misalign_o
);

  localparam int unsigned XLEN       = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              mis_q, mis_d;

  logic              misaligned_c;
  logic [XLEN-1:0]   target_c;

  // Redirect target: word-aligned, or the trap vector when trapping is enabled
  always_comb begin
    misaligned_c = TRAP_EN && (alu_data_i[1:0] != 2'b00);
    target_c     = misaligned_c ? TRAP_VEC : {alu_data_i[XLEN-1:2], 2'b00};
  end

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      pc4_q   <= XLEN'(RESET_PC + WORD_BYTES);
      drop_q  <= 1'b0;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    mis_d   = br_sel_i && misaligned_c && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        // The current address still goes out; its response is dropped later
        if (br_sel_i) begin
          pend_d = target_c;
          drop_d = 1'b1;
        end
        if (imem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q || br_sel_i) begin
            // Stale response: refetch from the most recent redirect target
            addr_d  = br_sel_i ? target_c : pend_q;
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rdata_i;
            pc_d    = addr_q;
            pc4_d   = XLEN'(addr_q + WORD_BYTES);
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (br_sel_i) begin
          pend_d = target_c;
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (br_sel_i) begin
          addr_d  = target_c;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!stall_i) begin
          addr_d  = pc4_q;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == REQ);
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc4_o         = pc4_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed sequences, a redirect vector table and
// a randomized run against a transaction-level model (honours FETCH_MISALIGN_TRAP_EN).
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        br_sel;
  logic [31:0] alu;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;

  fetch_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .br_sel_i     (br_sel),
    .alu_data_i   (alu),
    .stall_i      (stall),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .pc4_o        (pc4),
    .misalign_o   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc4;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) return 32'h0000_0100;
`endif
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic mis_expected(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00);
`else
    return (t[1:0] == 2'b00) && (t[1:0] != 2'b00);
`endif
  endfunction

  task automatic do_fetch(input logic [31:0] data);
    gnt = 1'b1;
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = data;
    tick();
    rvalid = 1'b0;
  endtask

  // Randomized-phase model state
  logic [31:0] exp_next, cur_pc, out_addr, rnd;
  logic        outstanding, redirected;
  logic        p_req, p_valid;
  logic [31:0] p_addr;
  int          delay, presented, last_present;

  initial begin
    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[1] = '{32'h0000_0202, 32'h0000_0100, 32'h0000_0104, 1'b1};
    vecs[3] = '{32'h0000_1237, 32'h0000_0100, 32'h0000_0104, 1'b1};
`else
    vecs[1] = '{32'h0000_0202, 32'h0000_0200, 32'h0000_0204, 1'b0};
    vecs[3] = '{32'h0000_1237, 32'h0000_1234, 32'h0000_1238, 1'b0};
`endif
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_0014, 1'b0};

    rst_n = 1'b0; br_sel = 1'b0; alu = '0; stall = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (3) tick();

    // Reset state
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk1("rst_mis", misalign, 1'b0);

    // First fetch after reset release
    rst_n = 1'b1;
    tick();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk1("wait_req_low", imem_req, 1'b0);
    rvalid = 1'b1; rdata = 32'hAAAA_0001;
    tick();
    rvalid = 1'b0;
    chk1("first_valid", instr_valid, 1'b1);
    chk("first_pc", pc, 32'h0);
    chk("first_pc4", pc4, 32'h4);
    chk("first_instr", instr, 32'hAAAA_0001);
    tick();
    chk1("second_req", imem_req, 1'b1);
    chk("second_addr", imem_addr, 32'h4);

    // Grant withheld for three request cycles
    for (int i = 0; i < 3; i++) begin
      chk1("nogrant_req", imem_req, 1'b1);
      chk("nogrant_addr", imem_addr, 32'h4);
      if (i < 2) tick();
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk1("grant_to_wait", imem_req, 1'b0);
    rvalid = 1'b1; rdata = mem(32'h4);
    tick();
    rvalid = 1'b0;
    chk("pc_after_wait", pc, 32'h4);

    // Four stalled cycles in HOLD
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("stall_valid", instr_valid, 1'b1);
      chk("stall_pc", pc, 32'h4);
      chk("stall_instr", instr, mem(32'h4));
      chk1("stall_no_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk1("unstall_req", imem_req, 1'b1);
    chk("unstall_addr", imem_addr, 32'h8);

    // Redirect while waiting on 0x8
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    br_sel = 1'b1; alu = 32'h200;
    tick();
    br_sel = 1'b0; alu = '0;
    chk1("wait_redir_valid", instr_valid, 1'b0);
    rvalid = 1'b1; rdata = mem(32'h8);
    tick();
    rvalid = 1'b0;
    chk1("drop_valid", instr_valid, 1'b0);
    chk1("drop_req", imem_req, 1'b1);
    chk("drop_addr", imem_addr, 32'h200);
    do_fetch(mem(32'h200));
    chk1("redir_valid", instr_valid, 1'b1);
    chk("redir_pc", pc, 32'h200);

    // Two redirects during REQ: current address still issued, latest target wins
    tick();
    chk("req_0x204", imem_addr, 32'h204);
    br_sel = 1'b1; alu = 32'h300;
    tick();
    chk1("req_redir_req", imem_req, 1'b1);
    chk("req_redir_stable", imem_addr, 32'h204);
    alu = 32'h400; gnt = 1'b1;
    tick();
    br_sel = 1'b0; gnt = 1'b0; alu = '0;
    rvalid = 1'b1; rdata = mem(32'h204);
    tick();
    rvalid = 1'b0;
    chk1("latest_valid", instr_valid, 1'b0);
    chk("latest_addr", imem_addr, 32'h400);
    do_fetch(mem(32'h400));
    chk("latest_pc", pc, 32'h400);

    // Redirect table, applied from HOLD with stall also high
    foreach (vecs[k]) begin
      stall = 1'b1; br_sel = 1'b1; alu = vecs[k].tgt;
      tick();
      stall = 1'b0; br_sel = 1'b0; alu = '0;
      chk1("tbl_req", imem_req, 1'b1);
      chk("tbl_addr", imem_addr, vecs[k].exp_addr);
      chk1("tbl_valid_drop", instr_valid, 1'b0);
      chk1("tbl_mis", misalign, vecs[k].exp_mis);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk1("tbl_mis_end", misalign, 1'b0);
      rvalid = 1'b1; rdata = mem(vecs[k].exp_addr);
      tick();
      rvalid = 1'b0;
      chk("tbl_pc", pc, vecs[k].exp_addr);
      chk("tbl_pc4", pc4, vecs[k].exp_pc4);
      chk("tbl_instr", instr, mem(vecs[k].exp_addr));
      tick();
      chk("tbl_next_addr", imem_addr, vecs[k].exp_pc4);
      do_fetch(mem(vecs[k].exp_pc4));
      chk("tbl_next_pc", pc, vecs[k].exp_pc4);
    end

    // Reset in WAIT aborts the transaction; stray responses are ignored
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    chk1("abort_req", imem_req, 1'b0);
    chk1("abort_valid", instr_valid, 1'b0);
    chk("abort_addr", imem_addr, 32'h0);
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    chk1("stray_idle_req", imem_req, 1'b1);
    chk1("stray_idle_valid", instr_valid, 1'b0);
    tick();
    chk1("stray_req_valid", instr_valid, 1'b0);
    chk("stray_req_addr", imem_addr, 32'h0);
    rvalid = 1'b0;

    // Randomized run against a transaction-level model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_next = 32'h0; cur_pc = 32'h0; out_addr = '0;
    outstanding = 1'b0; redirected = 1'b0;
    delay = 0; presented = 0; last_present = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gnt = ($urandom_range(0, 1) == 1);
      if (outstanding && delay == 0) begin
        rvalid = 1'b1;
        rdata  = mem(out_addr);
      end else begin
        rvalid = !outstanding && ($urandom_range(0, 9) == 0);
        rdata  = $urandom;
      end
      br_sel = (cyc >= 2) && ($urandom_range(0, 11) == 0);
      rnd = $urandom;
      alu = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (rnd & 32'hF)) : (rnd & 32'h0000_FFFF);
      stall = ($urandom_range(0, 9) < 4);
      if (outstanding) chk1("single_outstanding", imem_req, 1'b0);
      p_req = imem_req; p_addr = imem_addr; p_valid = instr_valid;
      tick();

      if (p_req && !gnt) begin
        chk1("rnd_req_held", imem_req, 1'b1);
        chk("rnd_addr_stable", imem_addr, p_addr);
      end
      if (p_req && gnt) begin
        outstanding = 1'b1;
        out_addr    = p_addr;
        delay       = $urandom_range(0, 3);
      end else if (outstanding) begin
        if (rvalid) outstanding = 1'b0;
        else if (delay > 0) delay--;
      end

      if (br_sel) begin
        exp_next   = redirect_target(alu);
        redirected = 1'b1;
      end else if (p_valid && !stall) begin
        exp_next = cur_pc + 32'd4;
      end

      if (p_valid && stall && !br_sel) begin
        chk1("rnd_hold_valid", instr_valid, 1'b1);
        chk("rnd_hold_pc", pc, cur_pc);
        chk("rnd_hold_instr", instr, mem(cur_pc));
      end
      if (instr_valid && !p_valid) begin
        chk("rnd_pc", pc, exp_next);
        chk("rnd_instr", instr, mem(exp_next));
        chk("rnd_pc4", pc4, exp_next + 32'd4);
        cur_pc       = exp_next;
        redirected   = 1'b0;
        presented++;
        last_present = cyc;
      end
      if (imem_req && !redirected) chk("rnd_req_addr", imem_addr, exp_next);
      chk1("rnd_mis", misalign, br_sel ? mis_expected(alu) : 1'b0);

      if (cyc - last_present > 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL progress: no instruction for %0d cycles (required at most 300)", cyc - last_present);
        last_present = cyc;
      end
    end
    br_sel = 1'b0; gnt = 1'b0; rvalid = 1'b0; stall = 1'b0;
    n_cmp++;
    if (presented < 100) begin
      n_fail++;
      $display("FAIL throughput: %0d instructions presented, required at least 100", presented);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
